// File: rtl/cw_capture_core.sv
// Trigger-centred logic analyser capture core: keeps a pre-trigger history in a
// circular buffer, fills the rest after the trigger and reads back oldest-first.
module cw_capture_core #(
    parameter int DATA_W         = 17,
    parameter int DEPTH          = 1024,
    parameter int PRE_TRIG       = 256,
    parameter int INPUT_PIPE_NUM = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        probe,
    input  logic [DATA_W-1:0]        trig_mask,
    input  logic [DATA_W-1:0]        trig_value,
    input  logic                     trig_mode,
    input  logic                     arm,
    input  logic                     abort,
    output logic [2:0]               state,
    output logic                     done,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH)-1:0] trig_pos
);

    localparam int            AW        = $clog2(DEPTH);
    localparam int            POST_N    = DEPTH - 1 - PRE_TRIG;
    localparam logic [AW-1:0] PRE_A     = AW'(PRE_TRIG);
    localparam logic [AW-1:0] PRE_LAST  = AW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
    localparam logic [AW-1:0] POST_LAST = AW'((POST_N > 0) ? POST_N - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, pre_cnt_q, post_cnt_q, trig_addr_q, trig_pos_q;
    logic              done_q, first_q;
    logic [DATA_W-1:0] s, s_prev_q, rd_data_q;
    logic              hit, mem_we, start;
    logic [AW-1:0]     rd_phys;
    logic [DATA_W-1:0] mem [DEPTH];

    generate
        if (INPUT_PIPE_NUM == 0) begin : g_nopipe
            assign s = probe;
        end else begin : g_pipe
            logic [DATA_W-1:0] pipe_q [INPUT_PIPE_NUM];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < INPUT_PIPE_NUM; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= probe;
                    for (int i = 1; i < INPUT_PIPE_NUM; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign s = pipe_q[INPUT_PIPE_NUM-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_prev_q <= '0;
        else        s_prev_q <= s;
    end

    // Edge mode has no valid previous sample on the first cycle of a capture.
    always_comb begin
        if (trig_mode) hit = (((s ^ s_prev_q) & trig_mask) != '0) && !first_q;
        else           hit = ((s ^ trig_value) & trig_mask) == '0;
    end

    assign start  = arm && !abort && (state_q == S_IDLE || state_q == S_DONE);
    assign mem_we = !abort && (state_q == S_PRE || state_q == S_WAIT ||
                               (state_q == S_POST && POST_N > 0));

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (arm) state_d = (PRE_TRIG == 0) ? S_WAIT : S_PRE;
                S_PRE:          if (pre_cnt_q == PRE_LAST) state_d = S_WAIT;
                S_WAIT:         if (hit) state_d = S_POST;
                S_POST:         if (POST_N == 0 || post_cnt_q == POST_LAST) state_d = S_DONE;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            first_q     <= 1'b0;
            wr_ptr_q    <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            trig_pos_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == S_DONE);
            first_q <= start;
            if (start) begin
                wr_ptr_q   <= '0;
                pre_cnt_q  <= '0;
                post_cnt_q <= '0;
            end else if (mem_we) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (state_q == S_PRE)  pre_cnt_q  <= pre_cnt_q + AW'(1);
                if (state_q == S_POST) post_cnt_q <= post_cnt_q + AW'(1);
            end
            if (!abort && state_q == S_WAIT && hit) begin
                trig_addr_q <= wr_ptr_q;
                trig_pos_q  <= PRE_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= s;
    end

    // Logical index 0 is the oldest retained sample, PRE_TRIG slots before the trigger.
    assign rd_phys = trig_addr_q - PRE_A + rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= mem[rd_phys];
    end

    assign state    = state_q;
    assign done     = done_q;
    assign trig_pos = trig_pos_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_cw_capture_core.sv
// Drives three capture cores (different PRE_TRIG / pipe depths) in lockstep and
// compares state, done, readback and trig_pos against a sample-history model.
module tb_cw_capture_core;

    localparam int DW      = 17;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int NI      = 3;
    localparam int CYC_MAX = 4096;

    logic clk = 1'b0;
    logic rst_n, arm, abort;
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] probeIn [NI];
    logic [DW-1:0] maskIn  [NI];
    logic [DW-1:0] valueIn [NI];
    logic          modeIn  [NI];
    logic [2:0]    stateO  [NI];
    logic          doneO   [NI];
    logic [DW-1:0] rdDataO [NI];
    logic [AW-1:0] trigPosO[NI];

    logic [DW-1:0] probeHist [NI][CYC_MAX];
    int cyc, vecCount, missCount, armEdge;
    int capT [NI];

    always #5 clk = ~clk;

    cw_capture_core #(.DATA_W(DW), .DEPTH(DEPTH), .PRE_TRIG(4), .INPUT_PIPE_NUM(0)) u0 (
        .clk(clk), .rst_n(rst_n), .probe(probeIn[0]), .trig_mask(maskIn[0]),
        .trig_value(valueIn[0]), .trig_mode(modeIn[0]), .arm(arm), .abort(abort),
        .state(stateO[0]), .done(doneO[0]), .rd_addr(rdAddr), .rd_data(rdDataO[0]),
        .trig_pos(trigPosO[0]));

    cw_capture_core #(.DATA_W(DW), .DEPTH(DEPTH), .PRE_TRIG(0), .INPUT_PIPE_NUM(2)) u1 (
        .clk(clk), .rst_n(rst_n), .probe(probeIn[1]), .trig_mask(maskIn[1]),
        .trig_value(valueIn[1]), .trig_mode(modeIn[1]), .arm(arm), .abort(abort),
        .state(stateO[1]), .done(doneO[1]), .rd_addr(rdAddr), .rd_data(rdDataO[1]),
        .trig_pos(trigPosO[1]));

    cw_capture_core #(.DATA_W(DW), .DEPTH(DEPTH), .PRE_TRIG(15), .INPUT_PIPE_NUM(1)) u2 (
        .clk(clk), .rst_n(rst_n), .probe(probeIn[2]), .trig_mask(maskIn[2]),
        .trig_value(valueIn[2]), .trig_mode(modeIn[2]), .arm(arm), .abort(abort),
        .state(stateO[2]), .done(doneO[2]), .rd_addr(rdAddr), .rd_data(rdDataO[2]),
        .trig_pos(trigPosO[2]));

    function automatic int preOf(input int i);
        case (i)
            0:       return 4;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    function automatic int pipeOf(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    // Sample seen by the trigger/storage logic at clock edge k.
    function automatic logic [DW-1:0] sampleAt(input int i, input int k);
        int j;
        j = k - pipeOf(i);
        if (j < 0) return '0;
        return probeHist[i][j];
    endfunction

    function automatic int findTrigger(input int i, input int a);
        logic [DW-1:0] cur, prv;
        for (int t = a + preOf(i) + 1; t <= a + 200; t++) begin
            cur = sampleAt(i, t);
            prv = sampleAt(i, t - 1);
            if (!modeIn[i] && (((cur ^ valueIn[i]) & maskIn[i]) == '0)) return t;
            if (modeIn[i] && t != a + 1 && (((cur ^ prv) & maskIn[i]) != '0)) return t;
        end
        return -1;
    endfunction

    // State expected after clock edge k of a capture armed at edge armEdge.
    function automatic int expState(input int i, input int k);
        int p, n, postLen;
        p = preOf(i);
        n = DEPTH - 1 - p;
        postLen = (n > 0) ? n : 1;
        if (k < armEdge + p)                return 1;
        if (capT[i] < 0 || k < capT[i])     return 2;
        if (k < capT[i] + postLen)          return 3;
        return 4;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        for (int i = 0; i < NI; i++) probeIn[i] = probeHist[i][cyc];
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic checkStates();
        int es;
        for (int i = 0; i < NI; i++) begin
            es = expState(i, cyc - 1);
            checkOutput($sformatf("state[%0d]@%0d", i, cyc - 1), 32'(stateO[i]), 32'(es));
            checkOutput($sformatf("done[%0d]@%0d", i, cyc - 1), 32'(doneO[i]), 32'(es == 4));
        end
    endtask

    task automatic checkIdle(input string tag);
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("%s.state[%0d]", tag, i), 32'(stateO[i]), 32'd0);
            checkOutput($sformatf("%s.done[%0d]", tag, i), 32'(doneO[i]), 32'd0);
        end
    endtask

    // kind: 0 counter, 1 held match, 2 bit0 toggle, 3 zero mask, 4 change at arm, 5 random, 6 never
    task automatic applyStimulus(input int kind);
        int a, h, pp, p;
        logic [DW-1:0] base, v, m;
        if (cyc + 300 >= CYC_MAX) begin
            $display("[TB] FAIL cycBudget: cycle %0d, limit %0d", cyc, CYC_MAX);
            $fatal(1, "[TB] stimulus storage exhausted");
        end
        a = cyc + 4;
        armEdge = a;
        for (int i = 0; i < NI; i++) begin
            pp = pipeOf(i);
            p = preOf(i);
            for (int k = cyc; k < cyc + 260; k++) probeHist[i][k] = DW'($urandom);
            base = DW'($urandom);
            valueIn[i] = DW'($urandom);
            case (kind)
                0: begin
                    modeIn[i] = 1'b0;
                    maskIn[i] = '1;
                    valueIn[i] = (i == 2) ? DW'(20) : DW'(10);
                    for (int k = cyc; k < cyc + 260; k++) probeHist[i][k] = DW'(k - a);
                end
                1: begin
                    modeIn[i] = 1'b0;
                    maskIn[i] = '1;
                    for (int k = cyc; k < cyc + 260; k++) probeHist[i][k] = valueIn[i];
                end
                2: begin
                    modeIn[i] = 1'b1;
                    maskIn[i] = DW'(1);
                    for (int k = cyc; k < cyc + 260; k++)
                        probeHist[i][k][0] = base[0] ^ (k >= a + 40);
                end
                3: begin
                    modeIn[i] = 1'b0;
                    maskIn[i] = '0;
                end
                4: begin
                    modeIn[i] = 1'b1;
                    maskIn[i] = DW'(1);
                    for (int k = cyc; k < cyc + 260; k++)
                        probeHist[i][k][0] = (k + pp >= a + 1) ^ (k + pp >= a + 30);
                end
                5: begin
                    modeIn[i] = 1'($urandom);
                    h = p + 1 + $urandom_range(0, 40);
                    if (!modeIn[i]) begin
                        m = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom & $urandom & $urandom);
                        v = DW'($urandom);
                        maskIn[i] = m;
                        valueIn[i] = v;
                        probeHist[i][a + h] = v;
                    end else begin
                        m = DW'($urandom);
                        if (m == '0) m = DW'(1);
                        maskIn[i] = m;
                        for (int k = cyc; k < cyc + 260; k++)
                            probeHist[i][k] = (probeHist[i][k] & ~m) | (((k >= a + h) ? ~base : base) & m);
                    end
                end
                default: begin
                    modeIn[i] = 1'b1;
                    maskIn[i] = '0;
                end
            endcase
        end
    endtask

    task automatic startCapture();
        while (cyc < armEdge) tick();
        for (int i = 0; i < NI; i++) capT[i] = findTrigger(i, armEdge);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checkStates();
    endtask

    task automatic runCapture(input bit rearm);
        int endK, n, lim;
        startCapture();
        endK = armEdge;
        for (int i = 0; i < NI; i++) begin
            n = DEPTH - 1 - preOf(i);
            lim = (capT[i] < 0) ? armEdge + 60 : capT[i] + ((n > 0) ? n : 1);
            if (lim > endK) endK = lim;
        end
        endK = endK + 1;
        while (cyc - 1 < endK) begin
            if (rearm && cyc == armEdge + 2) arm = 1'b1;
            tick();
            arm = 1'b0;
            checkStates();
        end
        for (int r = 0; r < DEPTH; r++) begin
            rdAddr = AW'(r);
            tick();
            checkStates();
            for (int i = 0; i < NI; i++)
                if (capT[i] >= 0)
                    checkOutput($sformatf("rdData[%0d][%0d]", i, r), 32'(rdDataO[i]),
                                32'(sampleAt(i, capT[i] - preOf(i) + r)));
        end
        for (int i = 0; i < NI; i++)
            checkOutput($sformatf("trigPos[%0d]", i), 32'(trigPosO[i]), 32'(preOf(i)));
    endtask

    initial begin
        vecCount = 0;
        missCount = 0;
        cyc = 0;
        armEdge = 0;
        rst_n = 1'b0;
        arm = 1'b0;
        abort = 1'b0;
        rdAddr = '0;
        for (int i = 0; i < NI; i++) begin
            maskIn[i] = '0;
            valueIn[i] = '0;
            modeIn[i] = 1'b0;
            capT[i] = -1;
            for (int k = 0; k < CYC_MAX; k++) probeHist[i][k] = DW'($urandom);
        end

        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("rst.state[%0d]", i), 32'(stateO[i]), 32'd0);
            checkOutput($sformatf("rst.done[%0d]", i), 32'(doneO[i]), 32'd0);
            checkOutput($sformatf("rst.trigPos[%0d]", i), 32'(trigPosO[i]), 32'd0);
            checkOutput($sformatf("rst.rdData[%0d]", i), 32'(rdDataO[i]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) tick();

        $display("[TB] counter capture");
        applyStimulus(0); runCapture(1'b0);
        $display("[TB] trigger true from arm, with ignored re-arm");
        applyStimulus(1); runCapture(1'b1);
        $display("[TB] single bit0 toggle, buffer wraps");
        applyStimulus(2); runCapture(1'b0);
        $display("[TB] zero mask, value mode");
        applyStimulus(3); runCapture(1'b1);
        $display("[TB] change on first cycle after arm is ignored");
        applyStimulus(4); runCapture(1'b0);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkIdle("abortDone");

        $display("[TB] abort with simultaneous arm while waiting");
        applyStimulus(6);
        capT[0] = -1;
        startCapture();
        for (int i = 0; i < NI; i++) capT[i] = -1;
        repeat (20) begin
            tick();
            checkStates();
        end
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        checkIdle("abortArm");
        tick();
        checkIdle("abortHold");

        $display("[TB] reset during post-trigger fill");
        applyStimulus(0);
        startCapture();
        while (cyc - 1 < capT[0] + 2) begin
            tick();
            checkStates();
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("midRst.state[%0d]", i), 32'(stateO[i]), 32'd0);
            checkOutput($sformatf("midRst.done[%0d]", i), 32'(doneO[i]), 32'd0);
            checkOutput($sformatf("midRst.trigPos[%0d]", i), 32'(trigPosO[i]), 32'd0);
            checkOutput($sformatf("midRst.rdData[%0d]", i), 32'(rdDataO[i]), 32'd0);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        checkIdle("postRst");
        applyStimulus(5); runCapture(1'b0);

        $display("[TB] randomized captures");
        repeat (8) begin
            applyStimulus(5);
            runCapture(1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
